// File: rtl/shrimp_pkg.sv
// Shared types and default sizes for the shrimp execution unit.
package shrimp_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 4;

  // Opcode encodings; anything above OP_MUL decodes as a NOP.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/shrimp_mul8.sv
// Sequential shift-add multiplier: one partial product per cycle, W cycles.
// 'start' loads the operands; 'done' is high in the last iteration cycle and
// 'product' then shows the final result (it already includes that last add).
module shrimp_mul8 #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             done,
  output logic [2*W-1:0]   product
);

  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic           run_q;

  // Accumulator plus the current partial product.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  assign product = acc_d;
  assign done    = run_q && (cnt_q == CNT_W'(W - 1));

  // Operand load on start, one shift-add step per cycle while running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[W-1:1]};
      cnt_q    <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/shrimp_exec_unit.sv
// Shrimp execution unit: single-cycle ALU ops plus a multi-cycle multiply,
// writing results to an external register file through a registered port.
//
// Handshake: an instruction transfers on a rising clock edge where
// issue_valid && issue_ready; issue_ready is low only while a multiply is in
// progress, and the issuer must hold its fields stable until the transfer.
module shrimp_exec_unit #(
  parameter int DATA_W = shrimp_pkg::DATA_W,
  parameter int REG_AW = shrimp_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] issue_ra,
  input  logic [REG_AW-1:0] issue_rb,
  output logic [REG_AW-1:0] reg_r_a_addr,
  output logic [REG_AW-1:0] reg_r_b_addr,
  input  logic [DATA_W-1:0] reg_r_a_val,
  input  logic [DATA_W-1:0] reg_r_b_val,
  output logic [REG_AW-1:0] reg_w_addr,
  output logic [DATA_W-1:0] reg_w_val,
  output logic              reg_w_enable,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy
);

  import shrimp_pkg::*;

  state_t              state_q, state_d;
  op_t                 op;
  logic                accept;
  logic [DATA_W-1:0]   opa, opb;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_writes;
  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  logic [REG_AW-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_val_q, w_val_d;
  logic                w_en_q, w_en_d;
  logic                wb_c_q, wb_c_d;     // carry that goes with the pending write
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;

  assign op          = op_t'(issue_op);
  assign issue_ready = (state_q != ST_MUL);
  assign accept      = issue_valid && issue_ready;
  assign busy        = (state_q != ST_IDLE);

  assign reg_r_a_addr = issue_ra;
  assign reg_r_b_addr = issue_rb;

  // Operand capture, forwarding the in-flight write while it is in WB.
  always_comb begin
    opa = reg_r_a_val;
    opb = reg_r_b_val;
    if (state_q == ST_WB && issue_ra == w_addr_q) opa = w_val_q;
    if (state_q == ST_WB && issue_rb == w_addr_q) opb = w_val_q;
  end

  // Single-cycle ALU; NOP, MUL and undefined encodings produce no write here.
  always_comb begin
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_writes = 1'b1;
    case (op)
      OP_MOV: alu_res = opa;
      OP_ADD: {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
      OP_SUB: begin
        alu_res = opa - opb;
        alu_c   = (opa < opb);
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_SHL: begin
        alu_res = {opa[DATA_W-2:0], 1'b0};
        alu_c   = opa[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, opa[DATA_W-1:1]};
        alu_c   = opa[0];
      end
      default: alu_writes = 1'b0;
    endcase
  end

  shrimp_mul8 #(.W(DATA_W)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM next state, write-port next values and flag update at the commit edge.
  always_comb begin
    state_d   = state_q;
    w_addr_d  = w_addr_q;
    w_val_d   = w_val_q;
    w_en_d    = 1'b0;
    wb_c_d    = wb_c_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    mul_start = 1'b0;

    // The write held during WB commits at the edge that ends WB.
    if (state_q == ST_WB) begin
      flag_z_d = (w_val_q == '0);
      flag_c_d = wb_c_q;
    end

    case (state_q)
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_WB;
          w_val_d = mul_product[DATA_W-1:0];
          wb_c_d  = |mul_product[2*DATA_W-1:DATA_W];
          w_en_d  = 1'b1;
        end
      end
      ST_IDLE, ST_WB: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (op == OP_MUL) begin
            state_d   = ST_MUL;
            w_addr_d  = issue_rd;
            mul_start = 1'b1;
          end else if (alu_writes) begin
            state_d  = ST_WB;
            w_addr_d = issue_rd;
            w_val_d  = alu_res;
            wb_c_d   = alu_c;
            w_en_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered write-port / flag storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      w_addr_q <= '0;
      w_val_q  <= '0;
      w_en_q   <= 1'b0;
      wb_c_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr_d;
      w_val_q  <= w_val_d;
      w_en_q   <= w_en_d;
      wb_c_q   <= wb_c_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign reg_w_addr   = w_addr_q;
  assign reg_w_val    = w_val_q;
  assign reg_w_enable = w_en_q;
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;

endmodule

// File: tb/tb_shrimp_exec_unit.sv
// Directed bench for shrimp_exec_unit with a behavioural register file.
module tb_shrimp_exec_unit;

  import shrimp_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          issue_valid;
  logic          issue_ready;
  logic [3:0]    issue_op;
  logic [AW-1:0] issue_rd, issue_ra, issue_rb;
  logic [AW-1:0] reg_r_a_addr, reg_r_b_addr;
  logic [DW-1:0] reg_r_a_val, reg_r_b_val;
  logic [AW-1:0] reg_w_addr;
  logic [DW-1:0] reg_w_val;
  logic          reg_w_enable;
  logic          flag_z, flag_c, busy;

  shrimp_exec_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_rd     (issue_rd),
    .issue_ra     (issue_ra),
    .issue_rb     (issue_rb),
    .reg_r_a_addr (reg_r_a_addr),
    .reg_r_b_addr (reg_r_b_addr),
    .reg_r_a_val  (reg_r_a_val),
    .reg_r_b_val  (reg_r_b_val),
    .reg_w_addr   (reg_w_addr),
    .reg_w_val    (reg_w_val),
    .reg_w_enable (reg_w_enable),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .busy         (busy)
  );

  // ---------------- register file model ----------------
  logic [DW-1:0] rf [16];
  int            wr_count = 0;
  assign reg_r_a_val = rf[reg_r_a_addr];
  assign reg_r_b_val = rf[reg_r_b_addr];
  always @(posedge clock) begin
    if (reg_w_enable) begin
      rf[reg_w_addr] <= reg_w_val;
      wr_count       <= wr_count + 1;
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive(input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rd    = rd;
    issue_ra    = ra;
    issue_rb    = rb;
  endtask

  task automatic idle_issue();
    issue_valid = 1'b0;
    issue_op    = 4'd0;
  endtask

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          c;
  } vec_t;

  vec_t tbl [7];
  int   n;
  int   wr_snap;

  initial begin
    idle_issue();
    issue_rd = '0;
    issue_ra = '0;
    issue_rb = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;

    tbl[0] = '{OP_MOV, 8'h5A, 8'h00, 8'h5A, 1'b0};
    tbl[1] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
    tbl[2] = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0};
    tbl[3] = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0};
    tbl[4] = '{OP_SHL, 8'h81, 8'h00, 8'h02, 1'b1};
    tbl[5] = '{OP_SHR, 8'h81, 8'h00, 8'h40, 1'b1};
    tbl[6] = '{OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0};

    // Reset state while reset_n is held low.
    repeat (2) step();
    check("rst_ready", issue_ready, 1);
    check("rst_wen",   reg_w_enable, 0);
    check("rst_waddr", reg_w_addr, 0);
    check("rst_wval",  reg_w_val, 0);
    check("rst_flagz", flag_z, 0);
    check("rst_flagc", flag_c, 0);
    check("rst_busy",  busy, 0);
    reset_n = 1'b1;
    step();
    check("post_rst_ready", issue_ready, 1);

    // ADD r3,r1,r2 with 100+200: wraps to 44 with carry.
    rf[1] = 8'd100;
    rf[2] = 8'd200;
    drive(OP_ADD, 4'd3, 4'd1, 4'd2);
    step();
    idle_issue();
    check("add_wen_n1",  reg_w_enable, 1);
    check("add_waddr",   reg_w_addr, 3);
    check("add_wval",    reg_w_val, 44);
    check("add_busy_wb", busy, 1);
    step();
    check("add_wen_n2", reg_w_enable, 0);
    check("add_rf3",    rf[3], 44);
    check("add_flagc",  flag_c, 1);
    check("add_flagz",  flag_z, 0);
    check("add_idle",   busy, 0);

    // SUB r5,r4,r4 gives zero; SUB r6,r4,r1 borrows.
    rf[4] = 8'd5;
    drive(OP_SUB, 4'd5, 4'd4, 4'd4);
    step();
    idle_issue();
    step();
    check("sub0_rf5",   rf[5], 0);
    check("sub0_flagz", flag_z, 1);
    check("sub0_flagc", flag_c, 0);
    drive(OP_SUB, 4'd6, 4'd4, 4'd1);
    step();
    idle_issue();
    step();
    check("sub1_rf6",   rf[6], 161);
    check("sub1_flagc", flag_c, 1);
    check("sub1_flagz", flag_z, 0);

    // Back-to-back ADDs: the second reads r1 through forwarding.
    rf[1] = 8'd3;
    drive(OP_ADD, 4'd1, 4'd1, 4'd1);
    step();
    check("fwd1_wval", reg_w_val, 6);
    check("fwd_ready_wb", issue_ready, 1);
    drive(OP_ADD, 4'd2, 4'd1, 4'd1);
    step();
    idle_issue();
    check("fwd_rf1",   rf[1], 6);
    check("fwd2_wen",  reg_w_enable, 1);
    check("fwd2_addr", reg_w_addr, 2);
    check("fwd2_wval", reg_w_val, 12);
    step();
    check("fwd_rf2", rf[2], 12);
    check("fwd_wen_off", reg_w_enable, 0);

    // Table of single-cycle ops through r3 = op(r1, r2).
    for (int i = 0; i < 7; i++) begin
      rf[1] = tbl[i].a;
      rf[2] = tbl[i].b;
      drive(tbl[i].op, 4'd3, 4'd1, 4'd2);
      step();
      idle_issue();
      step();
      check($sformatf("tbl%0d_res", i), rf[3], tbl[i].res);
      check($sformatf("tbl%0d_c", i), flag_c, tbl[i].c);
      check($sformatf("tbl%0d_z", i), flag_z, (tbl[i].res == 0) ? 1 : 0);
    end

    // Register 0 is an ordinary destination.
    rf[2] = 8'd12;
    drive(OP_MOV, 4'd0, 4'd2, 4'd0);
    step();
    idle_issue();
    step();
    check("r0_write", rf[0], 12);

    // MUL r9,r7,r8: 13*11 = 143, ready low for exactly 8 cycles.
    rf[7] = 8'd13;
    rf[8] = 8'd11;
    drive(OP_MUL, 4'd9, 4'd7, 4'd8);
    step();
    idle_issue();
    check("mul_busy", busy, 1);
    check("mul_wen_busy", reg_w_enable, 0);
    n = 0;
    while (issue_ready !== 1'b1 && n < 20) begin
      n++;
      step();
    end
    check("mul_ready_low_cycles", n, 8);
    check("mul_wen_wb", reg_w_enable, 1);
    check("mul_wval",   reg_w_val, 143);
    step();
    check("mul_rf9",   rf[9], 143);
    check("mul_flagc", flag_c, 0);
    check("mul_flagz", flag_z, 0);

    // 20*20 = 400: low byte 144, high byte nonzero.
    rf[11] = 8'd20;
    drive(OP_MUL, 4'd12, 4'd11, 4'd11);
    step();
    idle_issue();
    n = 0;
    while (issue_ready !== 1'b1 && n < 20) begin
      n++;
      step();
    end
    check("mul2_ready_low_cycles", n, 8);
    step();
    check("mul2_rf12",  rf[12], 144);
    check("mul2_flagc", flag_c, 1);

    // Reset pulse in the 4th MUL cycle aborts the write.
    rf[10] = 8'd0;
    drive(OP_MUL, 4'd10, 4'd7, 4'd8);
    step();
    idle_issue();
    repeat (3) step();
    check("abort_in_mul", issue_ready, 0);
    wr_snap = wr_count;
    reset_n = 1'b0;
    #1;
    check("abort_async_busy",  busy, 0);
    check("abort_async_flagc", flag_c, 0);
    step();
    reset_n = 1'b1;
    repeat (12) step();
    check("abort_no_write", wr_count, wr_snap);
    check("abort_rf10",     rf[10], 0);
    check("abort_idle",     busy, 0);
    check("abort_ready",    issue_ready, 1);
    check("abort_flagz",    flag_z, 0);
    check("abort_flagc",    flag_c, 0);

    // Set z=1,c=1 (128+128), then NOP and an undefined opcode leave them.
    rf[13] = 8'd128;
    rf[15] = 8'd77;
    drive(OP_ADD, 4'd14, 4'd13, 4'd13);
    step();
    idle_issue();
    step();
    check("pre_nop_flagz", flag_z, 1);
    check("pre_nop_flagc", flag_c, 1);
    wr_snap = wr_count;
    drive(OP_NOP, 4'd15, 4'd13, 4'd13);
    step();
    idle_issue();
    check("nop_wen",  reg_w_enable, 0);
    check("nop_busy", busy, 0);
    step();
    drive(4'hC, 4'd15, 4'd13, 4'd13);
    step();
    idle_issue();
    check("undef_wen", reg_w_enable, 0);
    step();
    check("nop_no_write", wr_count, wr_snap);
    check("nop_rf15",     rf[15], 77);
    check("nop_flagz",    flag_z, 1);
    check("nop_flagc",    flag_c, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
